// File: rtl/uart_rx_framer.sv
`timescale 1ns/1ps
// UART receiver: majority-vote sampling, false-start rejection, framing/overrun pulses.
// Define UART_RX_PARITY_EN to add a parity bit (PARITY_ODD) and o_PARITY_ERR.
module uart_rx_framer #(
   parameter int unsigned CLKS_PER_BIT = 1250,
   parameter int unsigned SYNC_STAGES  = 3
`ifdef UART_RX_PARITY_EN
  ,parameter bit          PARITY_ODD   = 1'b0
`endif
) (
   input  logic       i_CLK,
   input  logic       i_RST,
   input  logic       i_RX,
   output logic [7:0] o_DATA,
   output logic       o_VALID,
   input  logic       i_READY,
   output logic       o_FRAME_ERR,
   output logic       o_OVERRUN,
`ifdef UART_RX_PARITY_EN
   output logic       o_PARITY_ERR,
`endif
   output logic       o_BUSY
);

   localparam logic [15:0] HALF_M1 = 16'(CLKS_PER_BIT / 2 - 1);
   localparam logic [15:0] FULL_M1 = 16'(CLKS_PER_BIT - 1);

`ifdef UART_RX_PARITY_EN
   typedef enum logic [2:0] {
      IDLE, START, DATA, PARITY, STOP, BREAK
   } state_t;
`else
   typedef enum logic [2:0] {
      IDLE, START, DATA, STOP, BREAK
   } state_t;
`endif

   state_t state_q, state_d;
   logic [SYNC_STAGES-1:0] sync_q, sync_d;
   logic [15:0] cnt_q, cnt_d;
   logic [2:0]  bidx_q, bidx_d;
   logic [7:0]  sh_q, sh_d;
   logic [7:0]  data_q, data_d;
   logic        valid_q, valid_d;
   logic        fe_q, fe_d;
   logic        ov_q, ov_d;
   logic        rx_prev_q, rx_prev_d;
`ifdef UART_RX_PARITY_EN
   logic        pe_q, pe_d;
   logic        par_bad_q, par_bad_d;
`endif

   logic rx_s, rx_m, ma, mb, mc;

   assign rx_s = sync_q[2];
   assign ma   = sync_q[SYNC_STAGES-1];
   assign mb   = sync_q[SYNC_STAGES-2];
   assign mc   = sync_q[SYNC_STAGES-3];
   assign rx_m = (ma & mb) | (ma & mc) | (mb & mc);

   always_comb begin
      sync_d    = {sync_q[SYNC_STAGES-2:0], i_RX};
      state_d   = state_q;
      cnt_d     = cnt_q + 16'd1;
      bidx_d    = bidx_q;
      sh_d      = sh_q;
      data_d    = data_q;
      valid_d   = valid_q;
      fe_d      = 1'b0;
      ov_d      = 1'b0;
      rx_prev_d = rx_s;
`ifdef UART_RX_PARITY_EN
      pe_d      = 1'b0;
      par_bad_d = par_bad_q;
`endif
      if (valid_q && i_READY) valid_d = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (rx_prev_q && !rx_s) begin
               state_d = START;
               cnt_d   = '0;
            end
         end
         START: begin
            if (cnt_q == HALF_M1) begin
               cnt_d = '0;
               if (rx_m) begin
                  state_d = IDLE;
               end else begin
                  state_d = DATA;
                  bidx_d  = 3'd0;
`ifdef UART_RX_PARITY_EN
                  par_bad_d = 1'b0;
`endif
               end
            end
         end
         DATA: begin
            if (cnt_q == FULL_M1) begin
               cnt_d  = '0;
               sh_d   = {rx_m, sh_q[7:1]};
               bidx_d = bidx_q + 3'd1;
`ifdef UART_RX_PARITY_EN
               if (bidx_q == 3'd7) state_d = PARITY;
`else
               if (bidx_q == 3'd7) state_d = STOP;
`endif
            end
         end
`ifdef UART_RX_PARITY_EN
         PARITY: begin
            if (cnt_q == FULL_M1) begin
               cnt_d   = '0;
               state_d = STOP;
               if (rx_m != ((^sh_q) ^ PARITY_ODD)) begin
                  pe_d      = 1'b1;
                  par_bad_d = 1'b1;
               end
            end
         end
`endif
         STOP: begin
            if (cnt_q == FULL_M1) begin
               cnt_d   = '0;
               state_d = IDLE;
               if (!rx_m) begin
                  fe_d    = 1'b1;
                  state_d = BREAK;
`ifdef UART_RX_PARITY_EN
               end else if (!par_bad_q) begin
`else
               end else begin
`endif
                  // Idle here early so a start edge late in the stop bit is seen
                  if (!valid_q || i_READY) begin
                     data_d  = sh_q;
                     valid_d = 1'b1;
                  end else begin
                     ov_d = 1'b1;
                  end
               end
            end
         end
         BREAK: begin
            if (rx_s) begin
               state_d = IDLE;
               cnt_d   = '0;
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   always_ff @(posedge i_CLK) begin
      if (i_RST) begin
         state_q   <= IDLE;
         sync_q    <= '1;
         cnt_q     <= '0;
         bidx_q    <= '0;
         sh_q      <= '0;
         data_q    <= '0;
         valid_q   <= 1'b0;
         fe_q      <= 1'b0;
         ov_q      <= 1'b0;
         rx_prev_q <= 1'b1;
`ifdef UART_RX_PARITY_EN
         pe_q      <= 1'b0;
         par_bad_q <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         sync_q    <= sync_d;
         cnt_q     <= cnt_d;
         bidx_q    <= bidx_d;
         sh_q      <= sh_d;
         data_q    <= data_d;
         valid_q   <= valid_d;
         fe_q      <= fe_d;
         ov_q      <= ov_d;
         rx_prev_q <= rx_prev_d;
`ifdef UART_RX_PARITY_EN
         pe_q      <= pe_d;
         par_bad_q <= par_bad_d;
`endif
      end
   end

   assign o_DATA      = data_q;
   assign o_VALID     = valid_q;
   assign o_FRAME_ERR = fe_q;
   assign o_OVERRUN   = ov_q;
   assign o_BUSY      = (state_q != IDLE);
`ifdef UART_RX_PARITY_EN
   assign o_PARITY_ERR = pe_q;
`endif

endmodule

// File: tb/tb_uart_rx_framer.sv
`timescale 1ns/1ps
// Directed bench for uart_rx_framer at 16 clocks per bit.
// Also covers the parity build when UART_RX_PARITY_EN is defined.
module tb_uart_rx_framer;

   localparam int CPB = 16;
`ifdef UART_RX_PARITY_EN
   localparam int NB = 11;
`else
   localparam int NB = 10;
`endif
   // 3 sync stages + edge detect + half bit, then the remaining bits to stop mid
   localparam int LAT = 3 + 1 + CPB / 2 + (NB - 1) * CPB;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       rx  = 1'b1;
   logic       rdy = 1'b1;
   logic [7:0] dout;
   logic       vld, fe, ov, busy;
`ifdef UART_RX_PARITY_EN
   logic       pe;
   logic       par_flip = 1'b0;
   int         pe_n = 0;
`endif

   int total = 0;
   int bad   = 0;
   int cyc = 0, vcyc = 0, vrise = 0, vrise_cyc = 0;
   int fe_n = 0, ov_n = 0, busy_n = 0;
   logic [7:0] vdata = 8'h00;
   logic       v_prev = 1'b0;
   int c0, v0, r0, f0, o0, b0;

   uart_rx_framer #(
      .CLKS_PER_BIT(CPB),
      .SYNC_STAGES (3)
   ) dut (
      .i_CLK      (clk),
      .i_RST      (rst),
      .i_RX       (rx),
      .o_DATA     (dout),
      .o_VALID    (vld),
      .i_READY    (rdy),
      .o_FRAME_ERR(fe),
      .o_OVERRUN  (ov),
`ifdef UART_RX_PARITY_EN
      .o_PARITY_ERR(pe),
`endif
      .o_BUSY     (busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      #1;
      cyc++;
      if (vld === 1'b1) vcyc++;
      if (vld === 1'b1 && v_prev !== 1'b1) begin
         vrise++;
         vrise_cyc = cyc;
         vdata = dout;
      end
      v_prev = vld;
      if (fe === 1'b1) fe_n++;
      if (ov === 1'b1) ov_n++;
      if (busy === 1'b1) busy_n++;
`ifdef UART_RX_PARITY_EN
      if (pe === 1'b1) pe_n++;
`endif
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic hold(input logic b, input int n);
      rx = b;
      repeat (n) @(negedge clk);
   endtask

   task automatic send(input logic [7:0] d, input logic stop);
      hold(1'b0, CPB);
      for (int i = 0; i < 8; i++) hold(d[i], CPB);
`ifdef UART_RX_PARITY_EN
      hold((^d) ^ par_flip, CPB);
`endif
      hold(stop, CPB);
   endtask

   task automatic snap();
      c0 = cyc;
      v0 = vcyc;
      r0 = vrise;
      f0 = fe_n;
      o0 = ov_n;
      b0 = busy_n;
   endtask

   initial begin
      repeat (3) @(negedge clk);
      chk("rst_data", 32'(dout), 32'h00);
      chk("rst_valid", 32'(vld), 32'h0);
      chk("rst_busy", 32'(busy), 32'h0);
      chk("rst_ferr", 32'(fe), 32'h0);
      chk("rst_ovr", 32'(ov), 32'h0);
      rst = 1'b0;
      hold(1'b1, 20);

      // 0xA5 with consumer ready
      snap();
      send(8'hA5, 1'b1);
      hold(1'b1, 2 * CPB);
      chk("a5_data", 32'(vdata), 32'hA5);
      chk("a5_vcycles", 32'(vcyc - v0), 32'd1);
      chk("a5_latency", 32'(vrise_cyc - c0), 32'(LAT));
      chk("a5_ferr", 32'(fe_n - f0), 32'd0);
      chk("a5_ovr", 32'(ov_n - o0), 32'd0);

      // 4-clock glitch rejected at half bit
      snap();
      hold(1'b0, 4);
      hold(1'b1, 3 * CPB);
      chk("glitch_seen", 32'(busy_n > b0), 32'd1);
      chk("glitch_busy", 32'(busy), 32'd0);
      chk("glitch_valid", 32'(vcyc - v0), 32'd0);
      chk("glitch_ferr", 32'(fe_n - f0), 32'd0);

      // framing error then held-low break
      snap();
      send(8'h3C, 1'b0);
      hold(1'b0, 40 * CPB);
      chk("brk_busy_low", 32'(busy), 32'd1);
      hold(1'b1, 2 * CPB);
      chk("brk_ferr", 32'(fe_n - f0), 32'd1);
      chk("brk_valid", 32'(vrise - r0), 32'd0);
      chk("brk_busy_rel", 32'(busy), 32'd0);

      // overrun with stalled consumer
      snap();
      rdy = 1'b0;
      send(8'h11, 1'b1);
      send(8'h22, 1'b1);
      hold(1'b1, 2 * CPB);
      chk("ovr_data", 32'(dout), 32'h11);
      chk("ovr_valid", 32'(vld), 32'd1);
      chk("ovr_pulse", 32'(ov_n - o0), 32'd1);
      chk("ovr_rises", 32'(vrise - r0), 32'd1);
      rdy = 1'b1;
      @(negedge clk);
      chk("ovr_accept", 32'(vld), 32'd0);
      chk("ovr_hold", 32'(dout), 32'h11);

      // 1-clock spike landing in the oldest stage at bit 3's sample
      snap();
      hold(1'b0, CPB);
      for (int i = 0; i < 8; i++) begin
         if (i == 3) begin
            hold(1'b1, 8);
            hold(1'b0, 1);
            hold(1'b1, CPB - 9);
         end else begin
            hold(1'b1, CPB);
         end
      end
`ifdef UART_RX_PARITY_EN
      hold(1'b0, CPB);
`endif
      hold(1'b1, CPB);
      hold(1'b1, 2 * CPB);
      chk("spike_data", 32'(vdata), 32'hFF);
      chk("spike_rises", 32'(vrise - r0), 32'd1);

      // reset mid-frame, then a clean frame
      snap();
      hold(1'b0, CPB);
      hold(1'b1, CPB);
      hold(1'b0, CPB / 2);
      rx  = 1'b1;
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      hold(1'b1, 3 * CPB);
      chk("mid_rst_busy", 32'(busy), 32'd0);
      chk("mid_rst_valid", 32'(vrise - r0), 32'd0);
      chk("mid_rst_ferr", 32'(fe_n - f0), 32'd0);
      snap();
      send(8'h0F, 1'b1);
      hold(1'b1, 2 * CPB);
      chk("post_rst_data", 32'(vdata), 32'h0F);
      chk("post_rst_rises", 32'(vrise - r0), 32'd1);
      chk("post_rst_lat", 32'(vrise_cyc - c0), 32'(LAT));

`ifdef UART_RX_PARITY_EN
      begin
         int p0;
         snap();
         p0 = pe_n;
         par_flip = 1'b1;
         send(8'h07, 1'b1);
         par_flip = 1'b0;
         hold(1'b1, 2 * CPB);
         chk("par_err", 32'(pe_n - p0), 32'd1);
         chk("par_valid", 32'(vrise - r0), 32'd0);
         chk("par_ferr", 32'(fe_n - f0), 32'd0);
      end
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/uart_rx_framer.md
Name: uart_rx_framer

Overview:
- Standalone UART serial receiver. Turns the asynchronous RX pin into validated 8-bit bytes on a valid/ready stream.
- Sits directly upstream of the UART peripheral's RX FIFO and drives its write side. The FIFO stalls it through the ready input.
- Adds three things to the receive path: majority-vote sampling, false-start rejection, and framing/overrun error reporting.

Parameters:
- CLKS_PER_BIT, 1250, system clocks per bit (9600 baud at 12 MHz). Legal range 8..65535.
- SYNC_STAGES, 3, depth of the RX synchronizer shift register. Minimum 3, because majority vote uses the last 3 stages.

Ports:
- i_CLK  input  1  system clock; all logic on rising edge.
- i_RST  input  1  synchronous active-high reset.
- i_RX  input  1  asynchronous serial line, idle high.
- o_DATA  output  8  received byte; stable while o_VALID=1.
- o_VALID  output  1  byte available.
- i_READY  input  1  consumer accepts; transfer occurs when o_VALID & i_READY.
- o_FRAME_ERR  output  1  one-cycle pulse: stop bit sampled low.
- o_OVERRUN  output  1  one-cycle pulse: byte completed while the previous byte was unaccepted.
- o_BUSY  output  1  high in any state other than IDLE.

Behaviour:
- Reset: synchronizer all ones, state IDLE, counters 0, o_DATA=0, o_VALID=0, o_FRAME_ERR=0, o_OVERRUN=0, o_BUSY=0. Reset mid-frame abandons the frame; no output pulse.
- Synchronizer: shift i_RX into the sync register every cycle.
  - rx_s = newest synchronized bit past stage 2.
  - rx_m = majority of the 3 oldest stages.
- Bit counter: 16-bit tick counter, cleared on every state entry, increments each cycle. Sample point is a counter value of:
  - CLKS_PER_BIT/2 - 1 (integer divide) in START;
  - CLKS_PER_BIT - 1 in DATA and STOP.
  - At each sample point the counter clears.
- States:
  - IDLE: falling edge (previous rx_s=1, current rx_s=0) -> START.
  - START: at half-bit sample: rx_m=1 -> IDLE (glitch rejected, no pulse); rx_m=0 -> DATA with bit index 0.
  - DATA: at each sample, shift rx_m into the shift register MSB-first-in, so bytes are LSB first on the wire. After bit index 7 -> STOP (or PARITY, see Optional Feature).
  - STOP: at sample:
    - rx_m=1 -> deliver byte, go to IDLE.
    - rx_m=0 -> pulse o_FRAME_ERR, discard byte, go to BREAK.
  - BREAK: wait until rx_s=1, then IDLE. A held-low break line reports exactly one framing error.
- Delivery: o_DATA/o_VALID update on the cycle after the stop sample, so latency is 1 clock after the stop-bit mid-sample.
  - If o_VALID=0, or o_VALID & i_READY in that same cycle: load the new byte, o_VALID=1.
  - Else (o_VALID & ~i_READY): keep the old byte, drop the new one, pulse o_OVERRUN for 1 cycle.
- Acceptance: o_VALID & i_READY with no new delivery clears o_VALID next cycle. o_DATA holds its last value.
- Back-to-back frames: returning to IDLE at the stop mid-sample lets a start edge in the second half of the stop bit be detected. Rate tolerance is ±4% or better.
- Error pulses never coincide with an o_VALID rising edge for the same frame.

Optional Feature:
- Macro UART_RX_PARITY_EN.
- When defined:
  - Extra parameter PARITY_ODD, default 0.
  - A PARITY state sits between DATA and STOP and samples one bit.
  - Extra output o_PARITY_ERR (1 bit, reset 0) pulses for 1 cycle when the sampled bit ≠ the even/odd parity of the data.
  - On a parity error the byte is discarded and the FSM still proceeds to STOP. A framing error in the same frame is also pulsed.
- When undefined: no PARITY state, no o_PARITY_ERR port, and the frame is exactly 10 bits.

Test Plan (CLKS_PER_BIT=16):
- Send 0xA5 (8N1), i_READY=1 -> o_DATA=0xA5, o_VALID high exactly 1 cycle, 1 clk after the stop mid-sample. No error pulses.
- 4-clock low glitch on idle line -> START aborts at half-bit, o_BUSY returns 0, no o_VALID/o_FRAME_ERR.
- Send 0x3C with stop bit forced low, then hold the line low 40 bits, then release -> single o_FRAME_ERR pulse, no o_VALID. o_BUSY drops after release.
- i_READY=0, send 0x11 then 0x22 back-to-back -> o_DATA stays 0x11 with o_VALID high. o_OVERRUN pulses once at the 0x22 stop. Raising i_READY transfers 0x11 and clears o_VALID.
- Single-cycle 1-clock noise spike inside a data bit at the sample point of 0xFF -> majority vote yields 0xFF.
- i_RST asserted mid-DATA of 0x55, released, then send 0x0F -> no output for the aborted frame, 0x0F received correctly. With UART_RX_PARITY_EN and PARITY_ODD=0, wrong parity on 0x07 -> o_PARITY_ERR pulse, no o_VALID.
